// File: rtl/signature_analyzer.sv
// BIST response analyzer: compacts scan-out data into a MISR, counts shift cycles,
// and on finish registers a pass/fail verdict that is held until the next init.
module signature_analyzer #(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      IN_W       = 1,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(16'h1021),
  parameter logic [WIDTH-1:0] SEED       = '0,
  parameter logic [WIDTH-1:0] GOLDEN     = '0,
  parameter int unsigned      EXP_CYCLES = 13299,
  parameter int unsigned      CNT_W      = $clog2(EXP_CYCLES + 1) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             mode,
  input  logic             running,
  input  logic             finish,
  input  logic [IN_W-1:0]  scan_in,
  output logic [WIDTH-1:0] signature,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             protocol_err
);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             perr_q, perr_d;

  logic [WIDTH-1:0] sig_shift;
  logic             match;
  logic             err_set;

  assign sig_shift = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ WIDTH'(scan_in);

  // A finish with no compacted cycles can never pass, even if the goldens happen to agree.
  assign match = (sig_q == GOLDEN) && (cnt_q == CNT_W'(EXP_CYCLES)) && (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    perr_d  = perr_q;
    err_set = 1'b0;

    if (init) begin
      state_d = StActive;
      sig_d   = SEED;
      cnt_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      perr_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          err_set = running | finish;
        end
        StActive: begin
          err_set = (mode & ~running) | (finish & (cnt_q == '0));
          if (finish) begin
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = match;
            fail_d  = ~match;
          end else if (running && mode) begin
            sig_d = sig_shift;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          end
        end
        StDone: begin
          err_set = running;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
      if (err_set) begin
        perr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      sig_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      perr_q  <= perr_d;
    end
  end

  assign signature    = sig_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_signature_analyzer.sv
// Self-checking bench for signature_analyzer: directed test-plan scenarios plus random
// strobe sequences, all scored against a behavioural model through an expectation queue.
module tb_signature_analyzer;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned IN_W       = 1;
  localparam logic [3:0]  POLY       = 4'h3;
  localparam logic [3:0]  SEED       = 4'h0;
  localparam logic [3:0]  GOLDEN     = 4'h5;
  localparam int unsigned EXP_CYCLES = 3;
  localparam int          CNT_MAX    = (1 << ($clog2(EXP_CYCLES + 1) + 1)) - 1;

  logic       clock = 1'b0;
  logic       reset, init, mode, running, finish;
  logic [0:0] scan_in;
  logic [3:0] signature;
  logic       done, pass, fail, protocol_err;

  signature_analyzer #(
    .WIDTH     (WIDTH),
    .IN_W      (IN_W),
    .POLY      (POLY),
    .SEED      (SEED),
    .GOLDEN    (GOLDEN),
    .EXP_CYCLES(EXP_CYCLES)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .init        (init),
    .mode        (mode),
    .running     (running),
    .finish      (finish),
    .scan_in     (scan_in),
    .signature   (signature),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] sig;
    logic       done;
    logic       pass;
    logic       fail;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Behavioural model: 0 = idle, 1 = armed, 2 = verdict held.
  int   m_state = 0;
  int   m_sig   = 0;
  int   m_cnt   = 0;
  exp_t m_out   = '{sig: 4'h0, done: 1'b0, pass: 1'b0, fail: 1'b0, err: 1'b0};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  task automatic model(input logic r, input logic i, input logic m, input logic ru,
                       input logic f, input logic s);
    bit e;
    if (r) begin
      m_state = 0; m_sig = 0; m_cnt = 0;
      m_out.done = 0; m_out.pass = 0; m_out.fail = 0; m_out.err = 0;
    end else if (i) begin
      m_state = 1; m_sig = SEED; m_cnt = 0;
      m_out.done = 0; m_out.pass = 0; m_out.fail = 0; m_out.err = 0;
    end else begin
      e = (m_state == 1 && m && !ru) || (m_state != 1 && ru) || (m_state == 0 && f) ||
          (m_state == 1 && f && m_cnt == 0);
      if (m_state == 1 && f) begin
        m_state    = 2;
        m_out.done = 1;
        m_out.pass = (m_sig == GOLDEN) && (m_cnt == EXP_CYCLES) && (m_cnt != 0);
        m_out.fail = !m_out.pass;
      end else if (m_state == 1 && ru && m) begin
        m_sig = ((m_sig * 2) % 16) ^ ((m_sig >= 8) ? int'(POLY) : 0) ^ int'(s);
        m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
      end
      if (e) m_out.err = 1;
    end
    m_out.sig = 4'(m_sig);
  endtask

  task automatic step(input logic r, input logic i, input logic m, input logic ru,
                      input logic f, input logic s);
    reset = r; init = i; mode = m; running = ru; finish = f; scan_in = s;
    model(r, i, m, ru, f, s);
    @(posedge clock);
    #1;
    exp_q.push_back(m_out);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic shift(input logic s);
    step(0, 0, 1, 1, 0, s);
  endtask

  task automatic check_sig(input string name, input logic [3:0] req);
    @(negedge clock);
    chk(name, signature, req);
  endtask

  task automatic check_verdict(input string name, input logic d, input logic p, input logic f,
                               input logic e);
    @(negedge clock);
    chk({name, "_done"}, done, d);
    chk({name, "_pass"}, pass, p);
    chk({name, "_fail"}, fail, f);
    chk({name, "_perr"}, protocol_err, e);
  endtask

  // Monitor: every clock the registered outputs are compared with the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("signature", signature, e.sig);
      chk("done", done, e.done);
      chk("pass", pass, e.pass);
      chk("fail", fail, e.fail);
      chk("protocol_err", protocol_err, e.err);
      chk("pass_and_fail", pass & fail, 1'b0);
    end
  end

  initial begin
    int r;
    logic [3:0] gold_pat [3];
    reset = 1; init = 0; mode = 0; running = 0; finish = 0; scan_in = 0;

    // Reset with random inputs, then a finish in idle only raises protocol_err.
    for (int k = 0; k < 3; k++) begin
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    check_verdict("reset", 0, 0, 0, 0);
    check_sig("reset_sig", 4'h0);
    step(0, 0, 0, 0, 1, 0);
    check_verdict("idle_finish", 0, 0, 0, 1);

    // Golden run.
    step(0, 1, 0, 0, 0, 0);
    check_sig("init_seed", SEED);
    gold_pat = '{4'h1, 4'h2, 4'h5};
    shift(1); check_sig("gold_s1", gold_pat[0]);
    shift(0); check_sig("gold_s2", gold_pat[1]);
    shift(1); check_sig("gold_s3", gold_pat[2]);
    step(0, 0, 0, 0, 1, 0);
    check_verdict("gold", 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check_verdict("done_refinish", 1, 1, 0, 0);

    // Mismatch: 1,1,1 -> 7.
    step(0, 1, 0, 0, 0, 0);
    shift(1); shift(1); shift(1);
    check_sig("mis_sig", 4'h7);
    step(0, 0, 0, 0, 1, 0);
    check_verdict("mis", 1, 0, 1, 0);

    // Feedback path: 1,0,1,1,0 -> 1,2,5,B,5 with count 5.
    step(0, 1, 0, 0, 0, 0);
    shift(1); shift(0); shift(1);
    shift(1); check_sig("fb_s4", 4'hB);
    shift(0); check_sig("fb_s5", 4'h5);
    step(0, 0, 0, 0, 1, 0);
    check_verdict("fb", 1, 0, 1, 0);

    // Capture cycles interleaved with the golden shifts.
    step(0, 1, 0, 0, 0, 0);
    shift(1); step(0, 0, 0, 1, 0, 1);
    shift(0); step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 1, 0, 1);
    shift(1);
    check_sig("cap_sig", 4'h5);
    step(0, 0, 0, 0, 1, 0);
    check_verdict("cap", 1, 1, 0, 0);

    // init together with finish from DONE: verdict cleared, armed, no new verdict.
    step(0, 1, 0, 0, 1, 0);
    check_verdict("init_fin", 0, 0, 0, 0);
    shift(1);
    check_sig("init_fin_armed", 4'h1);

    // finish immediately after init.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check_verdict("early_fin", 1, 0, 1, 1);

    // mode without running in ACTIVE: error, no shift.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1);
    check_sig("mode_norun_sig", SEED);
    check_verdict("mode_norun", 0, 0, 0, 1);

    // Restart from DONE with a fresh passing run.
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    check_verdict("restart_clear", 0, 0, 0, 0);
    shift(1); shift(0); shift(1);
    step(0, 0, 0, 0, 1, 0);
    check_verdict("restart", 1, 1, 0, 0);

    // Mid-test reset aborts; a following finish yields no verdict.
    step(0, 1, 0, 0, 0, 0);
    shift(1); shift(1);
    step(1, 0, 0, 0, 0, 0);
    check_sig("midrst_sig", 4'h0);
    check_verdict("midrst", 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    check_verdict("midrst_fin", 0, 0, 0, 1);

    // Counter saturation: 11 shifts ending in signature 5 must not pass.
    step(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) shift(0);
    shift(1); shift(0); shift(1);
    check_sig("sat_sig", 4'h5);
    step(0, 0, 0, 0, 1, 0);
    check_verdict("sat", 1, 0, 1, 0);

    // Random strobe sequences.
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 99));
      step((r < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
           1'($urandom),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
           1'($urandom));
    end

    idle();
    repeat (3) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
